// File: rtl/reg_file_sched_if.sv
// Port bundle between the register-file access scheduler, its three
// requesters (wb0, wb1, operand read) and the register file's port A.
interface reg_file_sched_if;
    logic        wb0_valid;
    logic [4:0]  wb0_rdi;
    logic [31:0] wb0_rd;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [4:0]  wb1_rdi;
    logic [31:0] wb1_rd;
    logic        wb1_ready;
    logic        rs_valid_in;
    logic [4:0]  rs1i_in;
    logic [4:0]  rs2i_in;
    logic        rs_ready;
    logic        rs_valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rf_rd;
    logic [4:0]  rf_rdi;
    logic        rf_rdw_rsrn;
    logic [4:0]  rf_rs1i;
    logic [4:0]  rf_rs2i;
    logic [31:0] rf_rs1;
    logic [31:0] rf_rs2;

    modport slave (
        input  wb0_valid, wb0_rdi, wb0_rd,
        input  wb1_valid, wb1_rdi, wb1_rd,
        input  rs_valid_in, rs1i_in, rs2i_in,
        input  rf_rs1, rf_rs2,
        output wb0_ready, wb1_ready, rs_ready,
        output rs_valid, rs1, rs2,
        output rf_rd, rf_rdi, rf_rdw_rsrn,
        output rf_rs1i, rf_rs2i
    );

    modport master (
        output wb0_valid, wb0_rdi, wb0_rd,
        output wb1_valid, wb1_rdi, wb1_rd,
        output rs_valid_in, rs1i_in, rs2i_in,
        output rf_rs1, rf_rs2,
        input  wb0_ready, wb1_ready, rs_ready,
        input  rs_valid, rs1, rs2,
        input  rf_rd, rf_rdi, rf_rdw_rsrn,
        input  rf_rs1i, rf_rs2i
    );
endinterface

// File: rtl/reg_file_sched.sv
// Register-file port-A scheduler: writes beat reads, wb0/wb1 round-robin.
// Optional read-starvation guard: REG_FILE_SCHED_STARVE_GUARD_EN.
module reg_file_sched #(
    parameter int STARVE_MAX = 4
) (
    input logic              clk,
    input logic              rst,
    reg_file_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_e;

    state_e      state_q, state_d;
    logic        rr_q, rr_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [4:0]  rs1i_q, rs1i_d;
    logic [4:0]  rs2i_q, rs2i_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        rs_valid_q, rs_valid_d;

    logic wr_req;
    logic force_rd;
    logic gnt_rd;
    logic gnt_w0;
    logic gnt_w1;

`ifdef REG_FILE_SCHED_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 2);

    logic [CW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!bus.rs_valid_in || gnt_rd)
            starve_d = '0;
        else if (gnt_w0 || gnt_w1)
            starve_d = starve_q + 1'b1;
    end

    assign force_rd = bus.rs_valid_in &&
                      (starve_q == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = |STARVE_MAX;
    assign force_rd = 1'b0;
`endif

    // rr_q set means wb1 wins the next wb0/wb1 tie
    always_comb begin
        wr_req = bus.wb0_valid || bus.wb1_valid;
        gnt_rd = !rst && bus.rs_valid_in &&
                 (force_rd || !wr_req);
        gnt_w0 = !rst && !gnt_rd && bus.wb0_valid &&
                 (!bus.wb1_valid || !rr_q);
        gnt_w1 = !rst && !gnt_rd && bus.wb1_valid &&
                 !gnt_w0;
    end

    assign bus.wb0_ready = gnt_w0;
    assign bus.wb1_ready = gnt_w1;
    assign bus.rs_ready  = gnt_rd;

    always_comb begin
        state_d    = IDLE;
        rr_d       = rr_q;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        rs1i_d     = rs1i_q;
        rs2i_d     = rs2i_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rs_valid_d = (state_q == READ);
        unique case (1'b1)
            gnt_rd: begin
                state_d = READ;
                rs1i_d  = bus.rs1i_in;
                rs2i_d  = bus.rs2i_in;
            end
            gnt_w0: begin
                state_d   = WRITE;
                wr_idx_d  = bus.wb0_rdi;
                wr_data_d = bus.wb0_rd;
                rr_d      = 1'b1;
            end
            gnt_w1: begin
                state_d   = WRITE;
                wr_idx_d  = bus.wb1_rdi;
                wr_data_d = bus.wb1_rd;
                rr_d      = 1'b0;
            end
            default: ;
        endcase
        if (state_q == READ) begin
            rs1_d = bus.rf_rs1;
            rs2_d = bus.rf_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            rs1i_q     <= '0;
            rs2i_q     <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            rs1i_q     <= rs1i_d;
            rs2i_q     <= rs2i_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rs_valid_q <= rs_valid_d;
        end
    end

    // x0 writes are granted but never reach the file
    assign bus.rf_rdw_rsrn = (state_q == WRITE) &&
                             (wr_idx_q != 5'd0);
    assign bus.rf_rdi   = wr_idx_q;
    assign bus.rf_rd    = wr_data_q;
    assign bus.rf_rs1i  = rs1i_q;
    assign bus.rf_rs2i  = rs2i_q;
    assign bus.rs1      = rs1_q;
    assign bus.rs2      = rs2_q;
    assign bus.rs_valid = rs_valid_q;

endmodule
